// File: rtl/data_generator.sv
// AXI-Stream test-packet source: ID word, running-index payload, inverted ones'-complement checksum word.
// Optional bit0 error injection on ID/DATA/CS words is compiled in when DATA_GEN_ERR_INJ_EN is defined.
module data_generator #(
    parameter int unsigned                     PACKET_WORD_LEN_BITS = 8,
    parameter int unsigned                     PACKET_LEN_WORDS     = 8,
    parameter logic [PACKET_WORD_LEN_BITS-1:0] PACKET_ID            = PACKET_WORD_LEN_BITS'(8'hAE)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            enable,
    input  logic [31:0]                     pkt_num,
    input  logic [15:0]                     gap_len,
`ifdef DATA_GEN_ERR_INJ_EN
    input  logic                            err_inj_id,
    input  logic                            err_inj_data,
    input  logic                            err_inj_cs,
`endif
    output logic [PACKET_WORD_LEN_BITS-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            busy,
    output logic                            done,
    output logic [31:0]                     PKT_CNT
);

    localparam int unsigned W     = PACKET_WORD_LEN_BITS;
    localparam int unsigned L     = PACKET_LEN_WORDS;
    localparam int unsigned IDX_W = $clog2(L) + 1;
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(L - 2);
    localparam int unsigned REQ_ID   = 2;
    localparam int unsigned REQ_DATA = 1;
    localparam int unsigned REQ_CS   = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_DATA,
        S_CS,
        S_GAP
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   tdata_n;
    logic           tvalid_n, tlast_n, busy_n, done_n;
    logic [31:0]    pkt_cnt_n;
    logic [W-1:0]   acc, acc_n, acc_add, cs_word, id_word;
    logic [W:0]     sum;
    logic [IDX_W-1:0] idx, idx_n;
    logic [31:0]    sent, sent_n, pkt_num_q, pkt_num_n;
    logic [15:0]    gap_len_q, gap_len_n, gap_cnt, gap_cnt_n;
    logic [2:0]     inj_pulse, req, req_n, req_eff;
    logic           xfer;

`ifdef DATA_GEN_ERR_INJ_EN
    assign inj_pulse = {err_inj_id, err_inj_data, err_inj_cs};
`else
    assign inj_pulse = 3'b000;
`endif

    assign xfer = m_axis_tvalid & m_axis_tready;

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            PKT_CNT       <= '0;
            acc           <= '0;
            idx           <= '0;
            sent          <= '0;
            pkt_num_q     <= '0;
            gap_len_q     <= '0;
            gap_cnt       <= '0;
            req           <= '0;
        end else begin
            state         <= state_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tlast  <= tlast_n;
            busy          <= busy_n;
            done          <= done_n;
            PKT_CNT       <= pkt_cnt_n;
            acc           <= acc_n;
            idx           <= idx_n;
            sent          <= sent_n;
            pkt_num_q     <= pkt_num_n;
            gap_len_q     <= gap_len_n;
            gap_cnt       <= gap_cnt_n;
            req           <= req_n;
        end
    end

    // Next-state, next-output and checksum datapath
    always_comb begin
        state_n   = state;
        tdata_n   = m_axis_tdata;
        tvalid_n  = m_axis_tvalid;
        tlast_n   = m_axis_tlast;
        done_n    = 1'b0;
        pkt_cnt_n = PKT_CNT;
        acc_n     = acc;
        idx_n     = idx;
        sent_n    = sent;
        pkt_num_n = pkt_num_q;
        gap_len_n = gap_len_q;
        gap_cnt_n = gap_cnt;
        req_eff   = req | inj_pulse;
        req_n     = req_eff;

        // End-around carry; the sum of two W-bit values plus carry never overflows again
        sum     = {1'b0, acc} + {1'b0, m_axis_tdata};
        acc_add = sum[W-1:0] + W'(sum[W]);
        cs_word = ~acc_add ^ W'(req_eff[REQ_CS]);
        id_word = PACKET_ID ^ W'(req_eff[REQ_ID]);

        unique case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n       = S_ID;
                    tdata_n       = id_word;
                    tvalid_n      = 1'b1;
                    tlast_n       = 1'b0;
                    req_n[REQ_ID] = 1'b0;
                    pkt_num_n     = pkt_num;
                    gap_len_n     = gap_len;
                    sent_n        = '0;
                end
            end
            S_ID: begin
                if (xfer) begin
                    acc_n = acc_add;
                    if (L > 2) begin
                        state_n         = S_DATA;
                        idx_n           = IDX_W'(1);
                        tdata_n         = W'(req_eff[REQ_DATA]);
                        req_n[REQ_DATA] = 1'b0;
                    end else begin
                        state_n       = S_CS;
                        tdata_n       = cs_word;
                        tlast_n       = 1'b1;
                        req_n[REQ_CS] = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    acc_n = acc_add;
                    if (idx == LAST_DATA_IDX) begin
                        state_n       = S_CS;
                        tdata_n       = cs_word;
                        tlast_n       = 1'b1;
                        req_n[REQ_CS] = 1'b0;
                    end else begin
                        // word index idx+1 carries value idx
                        idx_n   = idx + IDX_W'(1);
                        tdata_n = W'(idx);
                    end
                end
            end
            S_CS: begin
                if (xfer) begin
                    acc_n     = '0;
                    tlast_n   = 1'b0;
                    sent_n    = sent + 32'd1;
                    pkt_cnt_n = (PKT_CNT == 32'hFFFF_FFFF) ? PKT_CNT : PKT_CNT + 32'd1;
                    if ((pkt_num_q != 32'd0) && (sent_n == pkt_num_q)) begin
                        state_n  = S_IDLE;
                        tvalid_n = 1'b0;
                        done_n   = 1'b1;
                    end else if (!enable) begin
                        state_n  = S_IDLE;
                        tvalid_n = 1'b0;
                    end else if (gap_len_q == 16'd0) begin
                        state_n       = S_ID;
                        tdata_n       = id_word;
                        req_n[REQ_ID] = 1'b0;
                    end else begin
                        state_n   = S_GAP;
                        tvalid_n  = 1'b0;
                        gap_cnt_n = gap_len_q;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt <= 16'd1) begin
                    if (enable) begin
                        state_n       = S_ID;
                        tdata_n       = id_word;
                        tvalid_n      = 1'b1;
                        req_n[REQ_ID] = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt - 16'd1;
                end
            end
            default: begin
                state_n  = S_IDLE;
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule
